// File: rtl/bus_pkg.sv
// Shared definitions for the bus grant scheduler: FSM states, the idle
// MASTER code and the default sizing parameters.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } bus_state_e;

    localparam logic [2:0] NO_MASTER       = 3'b111;
    localparam int         N_REQ_DEF       = 6;
    localparam int         TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic         valid,
    output logic [2:0]   idx
);

    logic [3:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        pos   = 4'd0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(N)) begin
                pos = pos - 4'(N);
            end
            if (!valid && req[pos[2:0]]) begin
                valid = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/bus_grant_scheduler.sv
// Round-robin bus arbiter with one-cycle grant latency, a turnaround cycle
// between tenures and an ACK watchdog that revokes and blocks a stuck master.
module bus_grant_scheduler
    import bus_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             BUS_CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] BR,
    input  logic             ACK,
    output logic [N_REQ-1:0] BG,
    output logic [2:0]       MASTER,
    output logic             BUSY,
    output logic             TIMEOUT,
    output logic [1:0]       dbg_state_o
);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    bus_state_e       state_q;
    logic [2:0]       win_q;
    logic [2:0]       ptr_q;
    logic [7:0]       wd_q;
    logic [N_REQ-1:0] blocked_q;
    logic [N_REQ-1:0] blocked_d;
    logic [N_REQ-1:0] bg_q;
    logic [2:0]       master_q;
    logic             busy_q;
    logic             timeout_q;

    logic [N_REQ-1:0] eligible;
    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic [2:0]       ptr_next;
    logic [N_REQ-1:0] grant_vec;
    logic             win_req;
    logic             revoke;

    // Assertion is immediate through the cleared flops; release takes two edges.
    always_ff @(posedge BUS_CLK or negedge RST) begin
        if (!RST) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    assign eligible = BR & ~blocked_q;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign ptr_next  = (pick_idx == 3'(N_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
    assign grant_vec = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign win_req   = BR[win_q];
    // A dropped request on the expiry cycle makes win_req low, so the drop wins.
    assign revoke    = (state_q == HOLD) && win_req && !ACK &&
                       (wd_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        blocked_d = blocked_q & BR;
        if (revoke) begin
            blocked_d[win_q] = 1'b1;
        end
    end

    always_ff @(posedge BUS_CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            win_q     <= 3'd0;
            ptr_q     <= 3'd0;
            wd_q      <= 8'd0;
            blocked_q <= '0;
            bg_q      <= '0;
            master_q  <= NO_MASTER;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            blocked_q <= blocked_d;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q  <= GRANT;
                        win_q    <= pick_idx;
                        ptr_q    <= ptr_next;
                        bg_q     <= grant_vec;
                        master_q <= pick_idx;
                        busy_q   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (win_req) begin
                        state_q <= HOLD;
                        wd_q    <= 8'd0;
                    end else begin
                        state_q  <= RELEASE;
                        bg_q     <= '0;
                        master_q <= NO_MASTER;
                        busy_q   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!win_req || revoke) begin
                        state_q   <= RELEASE;
                        bg_q      <= '0;
                        master_q  <= NO_MASTER;
                        busy_q    <= 1'b0;
                        timeout_q <= revoke;
                    end else if (ACK) begin
                        wd_q <= 8'd0;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BG          = bg_q;
    assign MASTER      = master_q;
    assign BUSY        = busy_q;
    assign TIMEOUT     = timeout_q;
    assign dbg_state_o = state_q;

endmodule
